// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - shared constants and types for the register file
package reg_file_pkg;
   localparam int REG_COUNT     = 8;
   localparam int REG_ADDR_W    = 3;
   localparam int WIDTH_DEFAULT = 32;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;

   localparam reg_addr_t ZERO_REG = 3'd0;
endpackage

// File: rtl/reg_file_if.sv
// rtl/reg_file_if.sv - read/write port bundle of the register file
interface reg_file_if
   import reg_file_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) ();
   reg_addr_t          read_addr1;
   reg_addr_t          read_addr2;
   logic [WIDTH-1:0]   read_data1;
   logic [WIDTH-1:0]   read_data2;
   logic               write_en;
   reg_addr_t          write_addr;
   logic [WIDTH-1:0]   write_data;

   modport master (
      output read_addr1, read_addr2, write_en, write_addr, write_data,
      input  read_data1, read_data2
   );

   modport slave (
      input  read_addr1, read_addr2, write_en, write_addr, write_data,
      output read_data1, read_data2
   );
endinterface

// File: rtl/mux8_1.sv
// rtl/mux8_1.sv - one-bit 8:1 selector cell built from three 2:1 levels
module mux8_1 (
   input  logic a0,
   input  logic a1,
   input  logic a2,
   input  logic a3,
   input  logic a4,
   input  logic a5,
   input  logic a6,
   input  logic a7,
   input  logic sel0,
   input  logic sel1,
   input  logic sel2,
   output logic y
);
   logic l1_0, l1_1, l1_2, l1_3;
   logic l2_0, l2_1;

   // three levels of 2:1 selection, lowest select bit first
   always_comb begin
      l1_0 = sel0 ? a1 : a0;
      l1_1 = sel0 ? a3 : a2;
      l1_2 = sel0 ? a5 : a4;
      l1_3 = sel0 ? a7 : a6;
      l2_0 = sel1 ? l1_1 : l1_0;
      l2_1 = sel1 ? l1_3 : l1_2;
      y    = sel2 ? l2_1 : l2_0;
   end
endmodule

// File: rtl/reg_word.sv
// rtl/reg_word.sv - one WIDTH-bit register with sync reset and load enable
module reg_word #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);
   // reset wins over load so a write in the reset cycle is discarded
   always_ff @(posedge clk) begin
      if (reset)
         q <= '0;
      else if (load)
         q <= d;
   end
endmodule

// File: rtl/reg_file.sv
// rtl/reg_file.sv - eight-entry register file, r0 hardwired to zero
module reg_file
   import reg_file_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic       clk,
   input  logic       reset,
   reg_file_if.slave  bus
);
   logic [WIDTH-1:0]       regs [1:REG_COUNT-1];
   logic [REG_COUNT-1:1]   word_en;
   logic [WIDTH-1:0]       rd1;
   logic [WIDTH-1:0]       rd2;

   // one-hot write decode gated by write_en; the r0 output is never built
   always_comb begin
      word_en = '0;
      for (int r = 1; r < REG_COUNT; r++) begin
         if (bus.write_en && (bus.write_addr == r[REG_ADDR_W-1:0]))
            word_en[r] = 1'b1;
      end
   end

   for (genvar r = 1; r < REG_COUNT; r++) begin : g_word
      reg_word #(.WIDTH(WIDTH)) u_word (
         .clk   (clk),
         .reset (reset),
         .load  (word_en[r]),
         .d     (bus.write_data),
         .q     (regs[r])
      );
   end

   // a0 tied low gives the zero register without storage
   for (genvar b = 0; b < WIDTH; b++) begin : g_bit
      mux8_1 u_rd1 (
         .a0   (1'b0),
         .a1   (regs[1][b]),
         .a2   (regs[2][b]),
         .a3   (regs[3][b]),
         .a4   (regs[4][b]),
         .a5   (regs[5][b]),
         .a6   (regs[6][b]),
         .a7   (regs[7][b]),
         .sel0 (bus.read_addr1[0]),
         .sel1 (bus.read_addr1[1]),
         .sel2 (bus.read_addr1[2]),
         .y    (rd1[b])
      );
      mux8_1 u_rd2 (
         .a0   (1'b0),
         .a1   (regs[1][b]),
         .a2   (regs[2][b]),
         .a3   (regs[3][b]),
         .a4   (regs[4][b]),
         .a5   (regs[5][b]),
         .a6   (regs[6][b]),
         .a7   (regs[7][b]),
         .sel0 (bus.read_addr2[0]),
         .sel1 (bus.read_addr2[1]),
         .sel2 (bus.read_addr2[2]),
         .y    (rd2[b])
      );
   end

   assign bus.read_data1 = rd1;
   assign bus.read_data2 = rd2;
endmodule

// File: doc/reg_file.md
# reg_file

Eight-entry, WIDTH-bit general-purpose register file for the single-cycle datapath, upstream of the ALU operand path. Holds architectural register state and provides two combinational read ports, each built from the one-bit 8:1 selector cell replicated per bit. Also provides one synchronous write port driven by the writeback stage. Register 0 is hardwired to zero.

## Interface
- WIDTH, 32, data width of each register and of every data port.
- clk  input  1  rising-edge clock; all state updates on this edge.
- reset  input  1  synchronous, active-high; clears all registers on the next rising edge.
- read_addr1  input  3  register index for read port 1.
- read_addr2  input  3  register index for read port 2.
- read_data1  output  WIDTH  contents of register read_addr1.
- read_data2  output  WIDTH  contents of register read_addr2.
- write_en  input  1  write strobe, sampled at rising edge.
- write_addr  input  3  register index for the write.
- write_data  input  WIDTH  value written when write_en=1.

## Operation
- State: r1..r7, each WIDTH bits. r0 has no storage and always reads 0.
- Reset: when reset=1 at a rising edge, r1..r7 become 0.
  - Reset overrides any write in the same cycle.
  - With write_en=1 and reset=1 together, the write is discarded.
- Write: when reset=0 and write_en=1 at a rising edge, r[write_addr] takes write_data.
  - All other registers hold their value.
- Write to address 0 is ignored and leaves no state change.
- write_en=0 means no register changes, whatever write_addr and write_data are.
- Read: read_dataN equals r[read_addrN] combinationally.
  - read_addrN=0 gives all zeros.
  - Both ports may address the same register; both return the same value.
- No internal write-to-read bypass.
  - A read of write_addr in the write cycle returns the old value.
  - The new value appears after the rising edge.
- Write decode: a 3-to-8 one-hot decoder gated by write_en.
  - Exactly one register enable is active per write, none when write_en=0.
  - The r0 enable output is left unconnected.

## Timing
- Reset value of outputs: once reset has been applied at a rising edge, read_data1 and read_data2 are 0 for every address.
- Before the first reset, register contents are undefined (X in simulation).
- Write latency: 1 cycle. Data at edge k is visible on read ports immediately after edge k.
- Read latency: 0 cycles (combinational). Read address to data is the critical path:
  - 3 levels of 2:1 selection per bit.
  - Must fit the single-cycle budget together with the ALU.
- Back-to-back writes to the same register on consecutive edges: the last value wins. No hazard inside the block.
- Reset asserted mid-program: all state clears at that edge. Writes resume on the first edge with reset=0.

## Structure
- Shared package or header holds:
  - REG_COUNT=8
  - REG_ADDR_W=3
  - the ZERO_REG index constant 0
  - default WIDTH=32
- Sub-module reg_word:
  - WIDTH flip-flops with synchronous active-high reset and load enable.
  - Instantiated 7 times (r1..r7).
- Read ports: per port, WIDTH instances of the existing one-bit 8:1 mux cell (mux8_1).
  - Input a0 tied to 0; a1..a7 take bit i of r1..r7.
  - Selects: sel0=addr[0], sel1=addr[1], sel2=addr[2].
- Write decoder: a small combinational sub-block inside reg_file; no separate module required.

## Test plan
- Reset with write_en=1, write_addr=3, write_data=32'hFFFF_FFFF in the same cycle -> after the edge, all eight addresses read 32'h0 on both ports.
- Write r1..r7 with 32'h1111_1111 × index on successive edges -> each address reads its value and r0 reads 0.
  - Sweep read_addr1 and read_addr2 independently, including both ports on the same address.
- write_en=1, write_addr=0, write_data=32'hDEAD_BEEF -> r0 still reads 0 and r1..r7 are unchanged.
- Read r5 (holding 32'hAAAA_0000) while writing 32'h0000_5555 to r5 -> read_data1 is 32'hAAAA_0000 before the edge and 32'h0000_5555 after it.
- write_en=0 with write_addr=2, write_data=32'h1234_5678 -> r2 keeps its previous value.
- Program r4=32'hCAFE_F00D, assert reset for one cycle mid-sequence -> r4 reads 0 after the edge.
  - Then write r4=32'h0000_0001 with reset=0 -> reads 32'h0000_0001.
